// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg: opcode constants, FSM state encoding and pc_src encodings for the multi-cycle controller
package risc_ctrl_pkg;
  localparam logic [5:0] ALU_R  = 6'h00;
  localparam logic [5:0] ALU_I  = 6'h01;
  localparam logic [5:0] LD     = 6'h02;
  localparam logic [5:0] ST     = 6'h03;
  localparam logic [5:0] BR     = 6'h04;
  localparam logic [5:0] JMP    = 6'h05;
  localparam logic [5:0] ALU_IU = 6'h06;
  localparam logic [5:0] HALT   = 6'h3F;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;
endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// opcode_class: combinational opcode decoder feeding the multi-cycle control FSM
module opcode_class
  import risc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             is_alu_r,
  output logic             is_imm,
  output logic             is_unsigned,
  output logic             is_ld,
  output logic             is_st,
  output logic             is_br,
  output logic             is_jmp,
  output logic             is_halt,
  output logic             is_illegal
);
  logic is_alu_i;
  assign is_alu_r    = opcode == ALU_R;
  assign is_alu_i    = opcode == ALU_I;
  assign is_unsigned = opcode == ALU_IU;
  assign is_ld       = opcode == LD;
  assign is_st       = opcode == ST;
  assign is_br       = opcode == BR;
  assign is_jmp      = opcode == JMP;
  assign is_halt     = opcode == HALT;
  assign is_imm      = is_alu_i | is_unsigned | is_ld | is_st;
  assign is_illegal  = !(is_alu_r | is_imm | is_br | is_jmp | is_halt);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for the RISC datapath; MULTICYCLE_CTRL_PERF_EN adds perf counters
module multicycle_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
`ifdef MULTICYCLE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_imm,
  output logic             ext_zero,
  output logic             rf_we,
  output logic             rf_dst_rd,
  output logic             wb_mem,
  output logic             halted,
  output logic             illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] instr_cnt
  , output logic [CNT_W-1:0] stall_cnt
`endif
);
  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   is_alu_r, is_imm, is_unsigned, is_ld, is_st, is_br, is_jmp, is_halt, is_illegal;

  opcode_class #(.OPC_W(OPC_W)) u_class (
    .opcode     (opcode),
    .is_alu_r   (is_alu_r),
    .is_imm     (is_imm),
    .is_unsigned(is_unsigned),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_br      (is_br),
    .is_jmp     (is_jmp),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // next state and the purely combinational datapath controls of the current state
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src_imm  = 1'b0;
    ext_zero     = 1'b0;
    rf_we        = 1'b0;
    rf_dst_rd    = 1'b0;
    wb_mem       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_rd   = 1'b1;
        ir_load  = mem_ready;
        pc_write = mem_ready;
        state_d  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        illegal_d = is_illegal;
        state_d   = (is_halt | is_illegal) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_src_imm = is_imm;
        ext_zero    = is_unsigned;
        pc_write    = is_jmp | (is_br & zero);
        pc_src      = is_jmp ? PC_JMP : (is_br & zero) ? PC_BR : PC_PLUS4;
        state_d     = (is_ld | is_st) ? S_MEM : (is_br | is_jmp) ? S_FETCH : S_WB;
      end
      S_MEM: begin
        mem_addr_sel = 1'b1;
        alu_src_imm  = 1'b1;
        mem_rd       = is_ld;
        mem_wr       = is_st;
        state_d      = !mem_ready ? S_MEM : is_ld ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_dst_rd = is_alu_r;
        wb_mem    = is_ld;
        state_d   = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign illegal = illegal_q;

  // FSM state and the captured illegal-opcode flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d, instr_cnt_q, instr_cnt_d, stall_cnt_q, stall_cnt_d;

  // active cycles, retired decodes and memory wait cycles; all wrap naturally
  always_comb begin
    cyc_cnt_d   = cyc_cnt_q + CNT_W'(state_q != S_IDLE && state_q != S_HALT);
    instr_cnt_d = instr_cnt_q + CNT_W'(state_q == S_DECODE);
    stall_cnt_d = stall_cnt_q + CNT_W'((state_q == S_FETCH || state_q == S_MEM) && !mem_ready);
  end

  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import risc_ctrl_pkg::*;
  localparam logic [13:0] RD   = 14'h2000;
  localparam logic [13:0] WR   = 14'h1000;
  localparam logic [13:0] ASEL = 14'h0800;
  localparam logic [13:0] IRL  = 14'h0400;
  localparam logic [13:0] PCW  = 14'h0200;
  localparam logic [13:0] SJ   = 14'h0100;
  localparam logic [13:0] SB   = 14'h0080;
  localparam logic [13:0] IMM  = 14'h0040;
  localparam logic [13:0] EXZ  = 14'h0020;
  localparam logic [13:0] RFWE = 14'h0010;
  localparam logic [13:0] DST  = 14'h0008;
  localparam logic [13:0] WBM  = 14'h0004;
  localparam logic [13:0] HLT  = 14'h0002;
  localparam logic [13:0] ILL  = 14'h0001;
  localparam logic [13:0] NONE = 14'h0000;
  localparam logic [13:0] FOK  = RD | IRL | PCW;

  typedef struct {
    logic [13:0] e;
    string       n;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic mem_rd, mem_wr, mem_addr_sel, ir_load, pc_write, alu_src_imm, ext_zero;
  logic rf_we, rf_dst_rd, wb_mem, halted, illegal;
  logic [1:0] pc_src;
  logic [13:0] act;
  exp_t q[$];
  int checks = 0, errors = 0;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt, stall_cnt;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_imm(alu_src_imm), .ext_zero(ext_zero),
    .rf_we(rf_we), .rf_dst_rd(rf_dst_rd), .wb_mem(wb_mem), .halted(halted), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign act = {mem_rd, mem_wr, mem_addr_sel, ir_load, pc_write, pc_src, alu_src_imm,
                ext_zero, rf_we, rf_dst_rd, wb_mem, halted, illegal};

  // one cycle: drive inputs, queue the expected control word, advance past the edge
  task automatic step(input logic s, input logic [5:0] op, input logic z, input logic r,
                      input logic [13:0] e, input string n);
    exp_t x;
    start = s; opcode = op; zero = z; mem_ready = r;
    x.e = e; x.n = n;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string n);
    rst = 1'b1;
    step(1'b0, 6'h00, 1'b0, 1'b1, NONE, n);
    rst = 1'b0;
  endtask

  // monitor: mid-cycle, compare the DUT outputs against the next queued expectation
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (act !== x.e) begin
          errors++;
          $display("FAIL %s: got %b expected %b", x.n, act, x.e);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    @(posedge clk);
    #1;
    step(1'b0, 6'h00, 1'b0, 1'b1, NONE, "rst_outputs");
    rst = 1'b0;
    step(1'b1, 6'h00, 1'b0, 1'b0, NONE, "idle_start");
    step(1'b0, 6'h00, 1'b0, 1'b0, RD, "fetch_wait");
    rst = 1'b1;
    step(1'b0, 6'h00, 1'b0, 1'b0, NONE, "rst_mid_fetch");
    rst = 1'b0;
    step(1'b0, 6'h00, 1'b0, 1'b1, NONE, "idle_hold0");
    step(1'b0, 6'h00, 1'b0, 1'b1, NONE, "idle_hold1");
    // ALU_IU, ALU_R, ALU_I back to back with zero-wait memory
    step(1'b1, ALU_IU, 1'b0, 1'b1, NONE, "iu_idle");
    step(1'b0, ALU_IU, 1'b0, 1'b1, FOK, "iu_fetch");
    step(1'b0, ALU_IU, 1'b0, 1'b1, NONE, "iu_decode");
    step(1'b0, ALU_IU, 1'b0, 1'b1, IMM | EXZ, "iu_exec");
    step(1'b0, ALU_IU, 1'b0, 1'b1, RFWE, "iu_wb");
    step(1'b0, ALU_R, 1'b0, 1'b1, FOK, "r_fetch");
    step(1'b0, ALU_R, 1'b0, 1'b1, NONE, "r_decode");
    step(1'b0, ALU_R, 1'b1, 1'b1, NONE, "r_exec");
    step(1'b0, ALU_R, 1'b0, 1'b1, RFWE | DST, "r_wb");
    step(1'b0, ALU_I, 1'b0, 1'b1, FOK, "i_fetch");
    step(1'b0, ALU_I, 1'b0, 1'b1, NONE, "i_decode");
    step(1'b0, ALU_I, 1'b0, 1'b1, IMM, "i_exec");
    step(1'b0, ALU_I, 1'b0, 1'b1, RFWE, "i_wb");
    step(1'b0, ALU_I, 1'b0, 1'b0, RD, "i_refetch");
    // LD with three MEM wait cycles
    do_reset("rst_before_ld");
    step(1'b1, LD, 1'b0, 1'b1, NONE, "ld_idle");
    step(1'b0, LD, 1'b0, 1'b1, FOK, "ld_fetch");
    step(1'b0, LD, 1'b0, 1'b0, NONE, "ld_decode");
    step(1'b0, LD, 1'b0, 1'b0, IMM, "ld_exec");
    step(1'b0, LD, 1'b0, 1'b0, RD | ASEL | IMM, "ld_mem_w0");
    step(1'b0, LD, 1'b0, 1'b0, RD | ASEL | IMM, "ld_mem_w1");
    step(1'b0, LD, 1'b0, 1'b0, RD | ASEL | IMM, "ld_mem_w2");
    step(1'b0, LD, 1'b0, 1'b1, RD | ASEL | IMM, "ld_mem_done");
    step(1'b0, LD, 1'b0, 1'b0, RFWE | WBM, "ld_wb");
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
    checks++;
    if (cyc_cnt !== 32'd8) begin errors++; $display("FAIL cyc_cnt: got %0d expected 8", cyc_cnt); end
    checks++;
    if (instr_cnt !== 32'd1) begin errors++; $display("FAIL instr_cnt: got %0d expected 1", instr_cnt); end
`endif
    step(1'b0, LD, 1'b0, 1'b0, RD, "ld_next_fetch");
    // BR taken, BR not taken, JMP
    do_reset("rst_before_br");
    step(1'b1, BR, 1'b0, 1'b1, NONE, "br_idle");
    step(1'b0, BR, 1'b0, 1'b1, FOK, "br_fetch");
    step(1'b0, BR, 1'b0, 1'b1, NONE, "br_decode");
    step(1'b0, BR, 1'b1, 1'b1, PCW | SB, "br_taken");
    step(1'b0, BR, 1'b1, 1'b1, FOK, "br2_fetch");
    step(1'b0, BR, 1'b1, 1'b1, NONE, "br2_decode");
    step(1'b0, BR, 1'b0, 1'b1, NONE, "br_not_taken");
    step(1'b0, JMP, 1'b0, 1'b0, RD, "br_nt_next");
    step(1'b0, JMP, 1'b0, 1'b1, FOK, "jmp_fetch");
    step(1'b0, JMP, 1'b0, 1'b1, NONE, "jmp_decode");
    step(1'b0, JMP, 1'b0, 1'b1, PCW | SJ, "jmp_exec");
    step(1'b0, JMP, 1'b0, 1'b0, RD, "jmp_next");
    // ST with zero-wait memory
    do_reset("rst_before_st");
    step(1'b1, ST, 1'b0, 1'b1, NONE, "st_idle");
    step(1'b0, ST, 1'b0, 1'b1, FOK, "st_fetch");
    step(1'b0, ST, 1'b0, 1'b1, NONE, "st_decode");
    step(1'b0, ST, 1'b0, 1'b1, IMM, "st_exec");
    step(1'b0, ST, 1'b0, 1'b1, WR | ASEL | IMM, "st_mem");
    step(1'b0, ST, 1'b0, 1'b0, RD, "st_next");
    // undefined opcode, then HALT opcode
    do_reset("rst_before_ill");
    step(1'b1, 6'h2A, 1'b0, 1'b1, NONE, "ill_idle");
    step(1'b0, 6'h2A, 1'b0, 1'b1, FOK, "ill_fetch");
    step(1'b0, 6'h2A, 1'b0, 1'b1, NONE, "ill_decode");
    step(1'b1, 6'h2A, 1'b0, 1'b1, HLT | ILL, "ill_halt0");
    step(1'b0, ALU_R, 1'b1, 1'b0, HLT | ILL, "ill_halt1");
    step(1'b1, LD, 1'b0, 1'b1, HLT | ILL, "ill_halt2");
    do_reset("rst_clears_ill");
    step(1'b1, HALT, 1'b0, 1'b1, NONE, "halt_idle");
    step(1'b0, HALT, 1'b0, 1'b1, FOK, "halt_fetch");
    step(1'b0, HALT, 1'b0, 1'b1, NONE, "halt_decode");
    step(1'b1, HALT, 1'b0, 1'b1, HLT, "halt0");
    step(1'b1, HALT, 1'b0, 1'b1, HLT, "halt1");
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RISC core; sequences fetch, decode, execute, memory and writeback over a shared datapath (ALU, register file, unified memory port, immediate extender).
- Drives all datapath enables and selects, including the extender mode select (sign vs zero) for the 16-bit immediate field.
- Sits beside the datapath top.
- Consumes the IR opcode, the ALU zero flag and the memory ready handshake.

Parameters:
- OPC_W, 6, opcode width (instr[31:26]).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution from IDLE; ignored in every other state.
- opcode  in  OPC_W  opcode field from IR; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_load  out  1  load IR from memory data.
- pc_write  out  1  update PC.
- pc_src  out  2  00 = PC+4, 01 = branch target (PC + ext_imm<<2), 10 = jump target.
- alu_src_imm  out  1  ALU operand B = extended immediate.
- ext_zero  out  1  extender mode: 1 = zero-extend, 0 = sign-extend.
- rf_we  out  1  register file write enable.
- rf_dst_rd  out  1  1 = destination is rd (R-type), 0 = destination is rt.
- wb_mem  out  1  writeback source: 1 = memory data, 0 = ALU result.
- halted  out  1  core stopped.
- illegal  out  1  stopped on an undefined opcode.

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE. Every output is 0 while rst is high and in IDLE. A reset during a memory wait drops mem_rd/mem_wr immediately.
- State set: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH on the next edge.
- FETCH:
  - mem_rd=1, mem_addr_sel=0.
  - Stays in FETCH while mem_ready=0.
  - In the cycle mem_ready=1: ir_load=1, pc_write=1, pc_src=00, then -> DECODE.
- DECODE: one cycle, no outputs asserted.
  - HALT opcode -> HALT.
  - Undefined opcode -> HALT with illegal set.
  - Any other opcode -> EXEC.
- EXEC (one cycle):
  - ALU_R: alu_src_imm=0 -> WB.
  - ALU_I: alu_src_imm=1, ext_zero=0 -> WB.
  - ALU_IU: alu_src_imm=1, ext_zero=1 -> WB.
  - LD/ST: alu_src_imm=1, ext_zero=0 -> MEM.
  - BR:
    - ext_zero=0.
    - If zero=1: pc_write=1, pc_src=01.
    - Then -> FETCH.
  - JMP: pc_write=1, pc_src=10 -> FETCH.
- MEM:
  - mem_addr_sel=1. LD drives mem_rd=1; ST drives mem_wr=1.
  - Requests are held until mem_ready=1.
  - In the mem_ready cycle: LD -> WB, ST -> FETCH.
- WB:
  - rf_we=1 for exactly one cycle.
  - rf_dst_rd=1 only for ALU_R.
  - wb_mem=1 only for LD.
  - Then -> FETCH.
- HALT:
  - halted=1; illegal holds its captured value.
  - Absorbing; only rst exits.
- Handshake and output timing:
  - mem_ready outside FETCH/MEM is ignored.
  - mem_ready may be 1 in the first request cycle, giving a zero-wait access.
  - ext_zero/alu_src_imm are valid for the whole EXEC cycle. Outside EXEC, ext_zero=0 and alu_src_imm=0, except in MEM where alu_src_imm keeps the address stable.
  - Outputs are combinational from state, opcode, zero and mem_ready; no output is registered.
  - illegal is a register set on DECODE -> HALT for undefined opcodes.
- Latency with zero-wait memory:
  - ALU ops: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BR/JMP: 3 cycles.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- With the macro, three extra outputs:
  - cyc_cnt [CNT_W]: increments every cycle outside IDLE/HALT.
  - instr_cnt [CNT_W]: increments on each DECODE -> EXEC/HALT transition.
  - stall_cnt [CNT_W]: increments each FETCH/MEM cycle with mem_ready=0.
- Counters are reset to 0 by rst and wrap modulo 2^CNT_W.
- Without the macro: the ports and logic are absent.

Decomposition:
- Package risc_ctrl_pkg holds:
  - Opcode constants: ALU_R=6'h00, ALU_I=6'h01, LD=6'h02, ST=6'h03, BR=6'h04, JMP=6'h05, ALU_IU=6'h06, HALT=6'h3F.
  - State enum.
  - pc_src encodings.
- Sub-module opcode_class: combinational, opcode -> {is_alu_r, is_imm, is_unsigned, is_ld, is_st, is_br, is_jmp, is_halt, is_illegal}.
- The FSM and output logic stay in multicycle_ctrl.

Test Plan:
- rst high mid-FETCH with mem_rd=1 -> mem_rd drops the same cycle, state IDLE. start=0 -> remains IDLE, all outputs 0.
- start, ALU_IU opcode, mem_ready always 1:
  - ir_load/pc_write at cycle 1.
  - ext_zero=1 and alu_src_imm=1 at cycle 3.
  - rf_we=1 with rf_dst_rd=0 at cycle 4, back to FETCH.
- LD with mem_ready low for 3 cycles in MEM:
  - mem_rd/mem_addr_sel=1 held 4 cycles.
  - Then WB with wb_mem=1.
  - PERF build: stall_cnt=3.
- BR with zero=1 -> pc_write=1, pc_src=01, ext_zero=0 in EXEC. With zero=0 -> pc_write=0, next state FETCH.
- Opcode 6'h2A -> halted=1, illegal=1. start/mem_ready pulses change nothing. Opcode HALT -> halted=1, illegal=0.
- ST with mem_ready=1 on the first MEM cycle -> mem_wr one cycle, rf_we never asserted, FETCH next.
